// File: rtl/riskbes_pkg.sv
// rtl/riskbes_pkg.sv - shared types and constants for the pipeline hazard controller
package riskbes_pkg;

  typedef enum logic {
    RUN,
    MEM_WAIT
  } hz_state_e;

  // Which priority level drove the control outputs this cycle (debug only)
  typedef enum logic [2:0] {
    HZ_NONE,
    HZ_DMEM,
    HZ_REDIRECT,
    HZ_LOAD_USE,
    HZ_IMEM
  } hazard_cause_e;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - pipeline status in, stall/flush controls and counters out
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  import riskbes_pkg::*;

  logic [4:0]       rs1_label_id_i;
  logic [4:0]       rs2_label_id_i;
  logic             uses_rs1_id_i;
  logic             uses_rs2_id_i;
  logic [4:0]       rd_id_ex_i;
  logic             is_load_instr_id_ex_i;
  logic             reg_wb_en_id_ex_i;
  logic             branch_taken_ex_i;
  logic             imem_busywait_i;
  logic             dmem_busywait_i;
  logic             cnt_clr_i;

  logic             pc_stall_o;
  logic             if_id_busywait_o;
  logic             id_ex_busywait_o;
  logic             ex_mem_busywait_o;
  logic             if_id_flush_o;
  logic             id_ex_flush_o;
  logic             mem_timeout_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;
  hazard_cause_e    hazard_cause_o;

  modport slave (
    input  rs1_label_id_i, rs2_label_id_i, uses_rs1_id_i, uses_rs2_id_i,
    input  rd_id_ex_i, is_load_instr_id_ex_i, reg_wb_en_id_ex_i,
    input  branch_taken_ex_i, imem_busywait_i, dmem_busywait_i, cnt_clr_i,
    output pc_stall_o, if_id_busywait_o, id_ex_busywait_o, ex_mem_busywait_o,
    output if_id_flush_o, id_ex_flush_o, mem_timeout_o,
    output stall_cnt_o, flush_cnt_o, hazard_cause_o
  );

  modport master (
    output rs1_label_id_i, rs2_label_id_i, uses_rs1_id_i, uses_rs2_id_i,
    output rd_id_ex_i, is_load_instr_id_ex_i, reg_wb_en_id_ex_i,
    output branch_taken_ex_i, imem_busywait_i, dmem_busywait_i, cnt_clr_i,
    input  pc_stall_o, if_id_busywait_o, id_ex_busywait_o, ex_mem_busywait_o,
    input  if_id_flush_o, id_ex_flush_o, mem_timeout_o,
    input  stall_cnt_o, flush_cnt_o, hazard_cause_o
  );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Clear wins over a same-cycle increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush priority decode, data-wait watchdog and event counters
module pipeline_hazard_ctrl
  import riskbes_pkg::*;
#(
  parameter int MEM_TIMEOUT = 1024,
  parameter int CNT_W       = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

  hz_state_e     state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic          timeout_q, timeout_d;
  hazard_cause_e cause;
  logic          load_use;
  logic          rs1_hit, rs2_hit;

  assign rs1_hit  = hz.uses_rs1_id_i && (hz.rs1_label_id_i == hz.rd_id_ex_i);
  assign rs2_hit  = hz.uses_rs2_id_i && (hz.rs2_label_id_i == hz.rd_id_ex_i);
  assign load_use = hz.is_load_instr_id_ex_i && hz.reg_wb_en_id_ex_i
                    && (hz.rd_id_ex_i != REG_X0) && (rs1_hit || rs2_hit);

  always_comb begin
    cause = HZ_NONE;
    if (rst_i)                     cause = HZ_NONE;
    else if (hz.dmem_busywait_i)   cause = HZ_DMEM;
    else if (hz.branch_taken_ex_i) cause = HZ_REDIRECT;
    else if (load_use)             cause = HZ_LOAD_USE;
    else if (hz.imem_busywait_i)   cause = HZ_IMEM;
  end

  always_comb begin
    hz.pc_stall_o        = 1'b0;
    hz.if_id_busywait_o  = 1'b0;
    hz.id_ex_busywait_o  = 1'b0;
    hz.ex_mem_busywait_o = 1'b0;
    hz.if_id_flush_o     = rst_i;
    hz.id_ex_flush_o     = rst_i;
    case (cause)
      HZ_DMEM: begin
        hz.pc_stall_o        = 1'b1;
        hz.if_id_busywait_o  = 1'b1;
        hz.id_ex_busywait_o  = 1'b1;
        hz.ex_mem_busywait_o = 1'b1;
      end
      HZ_REDIRECT: begin
        hz.if_id_flush_o = 1'b1;
        hz.id_ex_flush_o = 1'b1;
      end
      // Hold IF and ID; the bubble into ID/EX lets the load advance one stage
      HZ_LOAD_USE: begin
        hz.pc_stall_o       = 1'b1;
        hz.if_id_busywait_o = 1'b1;
        hz.id_ex_flush_o    = 1'b1;
      end
      HZ_IMEM: begin
        hz.pc_stall_o    = 1'b1;
        hz.if_id_flush_o = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      RUN: begin
        if (hz.dmem_busywait_i) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_ONE;
        end
      end
      MEM_WAIT: begin
        if (!hz.dmem_busywait_i) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_MAX) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
    timeout_d = timeout_q || (wait_cnt_d == WAIT_MAX);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign hz.mem_timeout_o  = timeout_q;
  assign hz.hazard_cause_o = cause;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (hz.pc_stall_o),
    .clr_i (hz.cnt_clr_i),
    .cnt_o (hz.stall_cnt_o)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (cause == HZ_REDIRECT),
    .clr_i (hz.cnt_clr_i),
    .cnt_o (hz.flush_cnt_o)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed and randomized checks of pipeline_hazard_ctrl against a behavioural model
module tb_pipeline_hazard_ctrl;
  import riskbes_pkg::*;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 3;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .hz    (hz)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: which rule wins, then a lookup of the control pattern for it
  function automatic hazard_cause_e m_cause();
    bit lu;
    lu = hz.is_load_instr_id_ex_i && hz.reg_wb_en_id_ex_i && hz.rd_id_ex_i != 0 &&
         ((hz.uses_rs1_id_i && hz.rs1_label_id_i == hz.rd_id_ex_i) ||
          (hz.uses_rs2_id_i && hz.rs2_label_id_i == hz.rd_id_ex_i));
    if (rst) return HZ_NONE;
    if (hz.dmem_busywait_i) return HZ_DMEM;
    if (hz.branch_taken_ex_i) return HZ_REDIRECT;
    if (lu) return HZ_LOAD_USE;
    if (hz.imem_busywait_i) return HZ_IMEM;
    return HZ_NONE;
  endfunction

  // {pc_stall, if_id_bw, id_ex_bw, ex_mem_bw, if_id_flush, id_ex_flush}
  function automatic logic [5:0] m_ctrl(input hazard_cause_e c);
    if (rst) return 6'b000011;
    case (c)
      HZ_DMEM:     return 6'b111100;
      HZ_REDIRECT: return 6'b000011;
      HZ_LOAD_USE: return 6'b110001;
      HZ_IMEM:     return 6'b100010;
      default:     return 6'b000000;
    endcase
  endfunction

  bit m_valid = 1'b0;
  int m_run, m_sc, m_fc;
  bit m_to;

  always @(posedge clk) begin
    hazard_cause_e c;
    logic [5:0] ctl;
    if (rst) begin
      m_valid = 1'b1;
      m_run = 0; m_to = 1'b0; m_sc = 0; m_fc = 0;
    end else if (m_valid) begin
      c   = m_cause();
      ctl = m_ctrl(c);
      m_run = hz.dmem_busywait_i ? m_run + 1 : 0;
      if (m_run >= MEM_TIMEOUT) m_to = 1'b1;
      if (hz.cnt_clr_i) begin
        m_sc = 0; m_fc = 0;
      end else begin
        if (ctl[5] && m_sc < CNT_MAX) m_sc++;
        if (c == HZ_REDIRECT && m_fc < CNT_MAX) m_fc++;
      end
    end
  end

  always @(negedge clk) begin
    hazard_cause_e c;
    logic [5:0] ctl;
    if (m_valid) begin
      c   = m_cause();
      ctl = m_ctrl(c);
      chk("m.pc_stall",     hz.pc_stall_o,        ctl[5]);
      chk("m.if_id_bw",     hz.if_id_busywait_o,  ctl[4]);
      chk("m.id_ex_bw",     hz.id_ex_busywait_o,  ctl[3]);
      chk("m.ex_mem_bw",    hz.ex_mem_busywait_o, ctl[2]);
      chk("m.if_id_flush",  hz.if_id_flush_o,     ctl[1]);
      chk("m.id_ex_flush",  hz.id_ex_flush_o,     ctl[0]);
      chk("m.cause",        int'(hz.hazard_cause_o), int'(c));
      chk("m.mem_timeout",  hz.mem_timeout_o,     m_to);
      chk("m.stall_cnt",    int'(hz.stall_cnt_o), m_sc);
      chk("m.flush_cnt",    int'(hz.flush_cnt_o), m_fc);
    end
  end

  task automatic idle();
    rst = 1'b0;
    hz.rs1_label_id_i = 5'd0; hz.rs2_label_id_i = 5'd0;
    hz.uses_rs1_id_i = 1'b0;  hz.uses_rs2_id_i = 1'b0;
    hz.rd_id_ex_i = 5'd0;
    hz.is_load_instr_id_ex_i = 1'b0; hz.reg_wb_en_id_ex_i = 1'b0;
    hz.branch_taken_ex_i = 1'b0;
    hz.imem_busywait_i = 1'b0; hz.dmem_busywait_i = 1'b0;
    hz.cnt_clr_i = 1'b0;
  endtask

  task automatic set_load_use();
    hz.is_load_instr_id_ex_i = 1'b1; hz.reg_wb_en_id_ex_i = 1'b1;
    hz.rd_id_ex_i = 5'd5; hz.rs1_label_id_i = 5'd5; hz.uses_rs1_id_i = 1'b1;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    int busy_left;
    idle();
    rst = 1'b1;
    nxt();
    smp();
    chk("rst.if_id_flush", hz.if_id_flush_o, 1);
    chk("rst.id_ex_flush", hz.id_ex_flush_o, 1);
    chk("rst.pc_stall",    hz.pc_stall_o, 0);
    chk("rst.stall_cnt",   int'(hz.stall_cnt_o), 0);
    chk("rst.flush_cnt",   int'(hz.flush_cnt_o), 0);
    chk("rst.mem_timeout", hz.mem_timeout_o, 0);
    nxt();
    idle();

    // Load-use: one bubble, then ID/EX holds the bubble and the stall drops
    set_load_use();
    smp();
    chk("lu.pc_stall",    hz.pc_stall_o, 1);
    chk("lu.if_id_bw",    hz.if_id_busywait_o, 1);
    chk("lu.id_ex_flush", hz.id_ex_flush_o, 1);
    chk("lu.id_ex_bw",    hz.id_ex_busywait_o, 0);
    nxt();
    hz.is_load_instr_id_ex_i = 1'b0; hz.reg_wb_en_id_ex_i = 1'b0; hz.rd_id_ex_i = 5'd0;
    smp();
    chk("lu.after_stall", hz.pc_stall_o, 0);
    chk("lu.stall_cnt",   int'(hz.stall_cnt_o), 1);

    nxt();
    idle();
    hz.is_load_instr_id_ex_i = 1'b1; hz.reg_wb_en_id_ex_i = 1'b1; hz.uses_rs1_id_i = 1'b1;
    smp();
    chk("x0.no_stall", hz.pc_stall_o, 0);
    nxt();
    hz.rd_id_ex_i = 5'd7; hz.rs1_label_id_i = 5'd3; hz.rs2_label_id_i = 5'd7;
    smp();
    chk("unused_rs2.no_stall", hz.pc_stall_o, 0);
    nxt();
    hz.uses_rs2_id_i = 1'b1;
    smp();
    chk("used_rs2.stall", hz.pc_stall_o, 1);

    // Branch during a cache miss: frozen, then redirect once the wait ends
    nxt();
    idle();
    hz.branch_taken_ex_i = 1'b1; hz.dmem_busywait_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("miss.if_id_flush", hz.if_id_flush_o, 0);
      chk("miss.id_ex_flush", hz.id_ex_flush_o, 0);
      chk("miss.ex_mem_bw",   hz.ex_mem_busywait_o, 1);
      nxt();
    end
    hz.dmem_busywait_i = 1'b0;
    smp();
    chk("miss.redirect_if_id", hz.if_id_flush_o, 1);
    chk("miss.redirect_id_ex", hz.id_ex_flush_o, 1);
    nxt();
    hz.branch_taken_ex_i = 1'b0;
    smp();
    chk("miss.flush_cnt",   int'(hz.flush_cnt_o), 1);
    chk("miss.no_timeout",  hz.mem_timeout_o, 0);

    // Branch over load-use
    nxt();
    set_load_use();
    hz.branch_taken_ex_i = 1'b1;
    smp();
    chk("br_lu.if_id_flush", hz.if_id_flush_o, 1);
    chk("br_lu.pc_stall",    hz.pc_stall_o, 0);
    chk("br_lu.if_id_bw",    hz.if_id_busywait_o, 0);

    // Watchdog: timeout visible after the 4th wait cycle, sticky until reset
    nxt();
    idle();
    hz.dmem_busywait_i = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      smp();
      chk("wd.timeout", hz.mem_timeout_o, (i >= 5) ? 1 : 0);
      nxt();
    end
    hz.dmem_busywait_i = 1'b0;
    smp();
    chk("wd.sticky", hz.mem_timeout_o, 1);
    nxt();
    rst = 1'b1;
    nxt();
    smp();
    chk("wd.cleared", hz.mem_timeout_o, 0);
    nxt();

    // Counter saturation, then clear racing a stall
    idle();
    hz.imem_busywait_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      smp();
      chk("sat.stall_cnt", int'(hz.stall_cnt_o), (i < 7) ? i : 7);
      nxt();
    end
    hz.cnt_clr_i = 1'b1;
    smp();
    chk("sat.if_id_flush", hz.if_id_flush_o, 1);
    nxt();
    hz.cnt_clr_i = 1'b0; hz.imem_busywait_i = 1'b0;
    smp();
    chk("sat.cleared", int'(hz.stall_cnt_o), 0);

    // Randomized traffic, checked cycle by cycle by the model
    busy_left = 0;
    for (int n = 0; n < 4000; n++) begin
      nxt();
      rst = ($urandom_range(0, 299) == 0);
      hz.cnt_clr_i = ($urandom_range(0, 63) == 0);
      if (busy_left > 0) begin
        hz.dmem_busywait_i = 1'b1;
        busy_left--;
      end else if ($urandom_range(0, 9) == 0) begin
        hz.dmem_busywait_i = 1'b1;
        busy_left = $urandom_range(0, 6);
      end else begin
        hz.dmem_busywait_i = 1'b0;
      end
      hz.branch_taken_ex_i     = ($urandom_range(0, 5) == 0);
      hz.imem_busywait_i       = ($urandom_range(0, 4) == 0);
      hz.is_load_instr_id_ex_i = 1'($urandom_range(0, 1));
      hz.reg_wb_en_id_ex_i     = ($urandom_range(0, 3) != 0);
      hz.rd_id_ex_i            = 5'($urandom_range(0, 3));
      hz.rs1_label_id_i        = 5'($urandom_range(0, 3));
      hz.rs2_label_id_i        = 5'($urandom_range(0, 3));
      hz.uses_rs1_id_i         = 1'($urandom_range(0, 1));
      hz.uses_rs2_id_i         = 1'($urandom_range(0, 1));
    end
    nxt();
    idle();
    smp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
